// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: op codes, FSM states,
// access-size decode and load/store predicates.
package lsu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [ALUOP_W-1:0]    aluop_t;

  localparam aluop_t EXE_OP_NOP = 8'h00, EXE_OP_ADD = 8'h01,
                     EXE_OP_LB  = 8'h20, EXE_OP_LH  = 8'h21, EXE_OP_LW = 8'h22,
                     EXE_OP_LBU = 8'h24, EXE_OP_LHU = 8'h25,
                     EXE_OP_SB  = 8'h28, EXE_OP_SH  = 8'h29, EXE_OP_SW = 8'h2a;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_DONE = 2'd3;

  typedef struct packed {
    logic [2:0] size;
    logic       sext;
  } acc_t;

  function automatic acc_t decode_acc(input aluop_t op);
    acc_t a;
    a = '0;
    case (op)
      EXE_OP_LB:  a = '{size: 3'd1, sext: 1'b1};
      EXE_OP_LH:  a = '{size: 3'd2, sext: 1'b1};
      EXE_OP_LW:  a = '{size: 3'd4, sext: 1'b0};
      EXE_OP_LBU: a = '{size: 3'd1, sext: 1'b0};
      EXE_OP_LHU: a = '{size: 3'd2, sext: 1'b0};
      EXE_OP_SB:  a = '{size: 3'd1, sext: 1'b0};
      EXE_OP_SH:  a = '{size: 3'd2, sext: 1'b0};
      EXE_OP_SW:  a = '{size: 3'd4, sext: 1'b0};
      default:    a = '0;
    endcase
    return a;
  endfunction

  function automatic logic is_load(input aluop_t op);
    return op inside {EXE_OP_LB, EXE_OP_LH, EXE_OP_LW, EXE_OP_LBU, EXE_OP_LHU};
  endfunction

  function automatic logic is_store(input aluop_t op);
    return op inside {EXE_OP_SB, EXE_OP_SH, EXE_OP_SW};
  endfunction

  function automatic logic is_mem(input aluop_t op);
    return is_load(op) || is_store(op);
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Memory-manager beat port: req/gnt for address phase, rvalid for read data.
interface mem_lsu_if #(
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 1
);
  logic                   req;
  logic                   we;
  logic [ADDR_W-1:0]      addr;
  logic [BUS_BYTES*8-1:0] wdata;
  logic [BUS_BYTES-1:0]   be;
  logic                   gnt;
  logic                   rvalid;
  logic [BUS_BYTES*8-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu_rdata_merge.sv
// Collects load bytes beat by beat and produces the sign/zero-extended value,
// including the bytes arriving on the current beat.
module lsu_rdata_merge #(
  parameter int DATA_W    = 32,
  parameter int BUS_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   cap,
  input  logic [2:0]             beat,
  input  logic [2:0]             lanes,
  input  logic [BUS_BYTES*8-1:0] rdata,
  input  logic [2:0]             size,
  input  logic                   sext,
  output logic [DATA_W-1:0]      ext
);

  logic [7:0]         bytes_q [4];
  logic [7:0]         bytes_n [4];
  logic [3:0]         base;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    bytes_n = bytes_q;
    base    = {1'b0, beat * lanes};
    for (int j = 0; j < BUS_BYTES; j++) begin
      if (cap && j < int'(lanes) && int'(base) + j < 4)
        bytes_n[2'(int'(base) + j)] = rdata[j*8 +: 8];
    end
  end

  always_ff @(posedge clk)
    bytes_q <= bytes_n;

  assign byte_s = bytes_n[0];
  assign half_s = {bytes_n[1], bytes_n[0]};

  always_comb begin
    case (size)
      3'd1:    ext = sext ? DATA_W'(byte_s) : DATA_W'(bytes_n[0]);
      3'd2:    ext = sext ? DATA_W'(half_s) : DATA_W'({bytes_n[1], bytes_n[0]});
      default: ext = DATA_W'({bytes_n[3], bytes_n[2], bytes_n[1], bytes_n[0]});
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: splits each access into bus beats and stalls EXE.
// Optional LSU_MISALIGN_EXC_EN turns misaligned half/word accesses into an exc_o pulse.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  reg_addr_t         wAddr_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wData_i,
  input  aluop_t            aluop_i,
  input  logic [ADDR_W-1:0] addr_i,
  output reg_addr_t         wAddr_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wData_o,
  mem_lsu_if.master         ram,
  output logic              stallFlag,
  output logic              exc_o
);

  localparam int BW = BUS_BYTES * 8;

  state_t            state_q;
  logic [2:0]        cnt_q, size_q;
  logic              sext_q, load_q, store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  reg_addr_t         waddr_q;

  acc_t              dec;
  logic              mem_op, mis, last_beat, cap, in_req;
  logic [2:0]        lanes, nbeats;
  logic [5:0]        shamt;
  logic [DATA_W-1:0] data_sh, rd_ext;

  assign dec    = decode_acc(aluop_i);
  assign mem_op = is_mem(aluop_i);
`ifdef LSU_MISALIGN_EXC_EN
  assign mis = (dec.size == 3'd2 && addr_i[0]) || (dec.size == 3'd4 && addr_i[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // Lanes per beat and beat count derive from the latched access size.
  assign lanes     = (32'(size_q) < BUS_BYTES) ? size_q : 3'(BUS_BYTES);
  assign nbeats    = 3'((32'(size_q) + BUS_BYTES - 1) / BUS_BYTES);
  assign last_beat = (cnt_q == nbeats - 3'd1);
  assign shamt     = {cnt_q * lanes, 3'b000};
  assign data_sh   = data_q >> shamt;

  assign in_req    = (state_q == ST_REQ);
  assign ram.req   = in_req;
  assign ram.we    = in_req && store_q;
  assign ram.be    = in_req ? BUS_BYTES'((32'd1 << lanes) - 32'd1) : '0;
  assign ram.addr  = addr_q + ADDR_W'(32'(cnt_q) * BUS_BYTES);
  assign ram.wdata = data_sh[BW-1:0];
  assign cap       = (state_q == ST_WAIT) && ram.rvalid;

  assign stallFlag = (state_q == ST_IDLE && mem_op) || state_q == ST_REQ || state_q == ST_WAIT;

  lsu_rdata_merge #(.DATA_W(DATA_W), .BUS_BYTES(BUS_BYTES)) u_merge (
    .clk   (clk),
    .cap   (cap),
    .beat  (cnt_q),
    .lanes (lanes),
    .rdata (ram.rdata),
    .size  (size_q),
    .sext  (sext_q),
    .ext   (rd_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      waddr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (mem_op) begin
          size_q  <= dec.size;
          sext_q  <= dec.sext;
          load_q  <= is_load(aluop_i);
          store_q <= is_store(aluop_i);
          addr_q  <= addr_i;
          data_q  <= wData_i;
          waddr_q <= wAddr_i;
          cnt_q   <= '0;
          state_q <= mis ? ST_DONE : ST_REQ;
        end
        ST_REQ: if (ram.gnt) begin
          if (load_q)         state_q <= ST_WAIT;
          else if (last_beat) state_q <= ST_DONE;
          else                cnt_q   <= cnt_q + 3'd1;
        end
        ST_WAIT: if (ram.rvalid) begin
          if (last_beat) state_q <= ST_DONE;
          else begin
            cnt_q   <= cnt_q + 3'd1;
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write-back register: ALU pass-through from IDLE, or the load result on the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wAddr_o <= '0;
      wreg_o  <= 1'b0;
      wData_o <= '0;
    end else begin
      wreg_o <= 1'b0;
      if (state_q == ST_IDLE && !mem_op) begin
        wAddr_o <= wAddr_i;
        wreg_o  <= wreg_i;
        wData_o <= wData_i;
      end else if (cap && last_beat) begin
        wAddr_o <= waddr_q;
        wreg_o  <= 1'b1;
        wData_o <= rd_ext;
      end
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic exc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exc_q <= 1'b0;
    else     exc_q <= (state_q == ST_IDLE) && mem_op && mis;
  end
  assign exc_o = exc_q;
`else
  assign exc_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: vector table on a 1-byte bus, plus hand sequences
// for reset during an access, misalignment and a delayed-grant store on a 2-byte bus.
module tb_mem_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_addr_t   waddr1, waddr_o1, waddr2, waddr_o2;
  logic        wreg1, wreg_o1, stall1, exc1, wreg2, wreg_o2, stall2, exc2;
  logic [31:0] wdata1, wdata_o1, addr1, wdata2, wdata_o2, addr2;
  aluop_t      op1, op2;

  mem_lsu_if #(.ADDR_W(32), .BUS_BYTES(1)) bus1 ();
  mem_lsu_if #(.ADDR_W(32), .BUS_BYTES(2)) bus2 ();

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .BUS_BYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .wAddr_i(waddr1), .wreg_i(wreg1), .wData_i(wdata1),
    .aluop_i(op1), .addr_i(addr1), .wAddr_o(waddr_o1), .wreg_o(wreg_o1),
    .wData_o(wdata_o1), .ram(bus1), .stallFlag(stall1), .exc_o(exc1));

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .BUS_BYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .wAddr_i(waddr2), .wreg_i(wreg2), .wData_i(wdata2),
    .aluop_i(op2), .addr_i(addr2), .wAddr_o(waddr_o2), .wreg_o(wreg_o2),
    .wData_o(wdata_o2), .ram(bus2), .stallFlag(stall2), .exc_o(exc2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Byte-wide memory model for dut1 with programmable grant delay and read latency.
  logic [7:0]  mem [0:1023];
  int          gnt_delay = 0, rv_extra = 0, wcnt = 0, pend = 0, pwait = 0;
  int          nbeat = 0, rv_cnt = 0;
  logic [31:0] paddr, h_addr;
  logic [31:0] beat_addr [8];
  logic        hold = 1'b0;
  logic [9:0]  h_ctl;

  initial begin
    bus1.gnt = 1'b0; bus1.rvalid = 1'b0; bus1.rdata = '0;
    forever begin
      @(negedge clk);
      bus1.gnt = 1'b0;
      bus1.rvalid = 1'b0;
      if (pend != 0) begin
        if (pwait == 0) begin
          bus1.rvalid = 1'b1;
          bus1.rdata  = mem[paddr[9:0]];
          pend = 0;
          rv_cnt++;
        end else pwait--;
      end
      if (hold && bus1.req) begin
        check("hold_addr", bus1.addr, h_addr);
        check("hold_ctl", {22'd0, bus1.we, bus1.be, bus1.wdata}, {22'd0, h_ctl});
      end
      if (bus1.req) begin
        if (wcnt < gnt_delay) wcnt++;
        else begin
          bus1.gnt = 1'b1;
          wcnt = 0;
          if (nbeat < 8) beat_addr[nbeat] = bus1.addr;
          nbeat++;
          if (bus1.we) begin
            if (bus1.be[0]) mem[bus1.addr[9:0]] = bus1.wdata;
          end else begin
            pend = 1; pwait = rv_extra; paddr = bus1.addr;
          end
        end
      end else wcnt = 0;
      hold   = bus1.req && !bus1.gnt;
      h_addr = bus1.addr;
      h_ctl  = {bus1.we, bus1.be, bus1.wdata};
    end
  end

  typedef struct {
    aluop_t      op;
    logic [31:0] addr;
    logic [31:0] din;
    reg_addr_t   rd;
    logic        wr;
    int          exp_stall;
    int          exp_beats;
    logic        exp_wreg;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [12];

  task automatic run_vec(input vec_t v, input int id);
    int st, c;
    nbeat = 0;
    op1 = v.op; addr1 = v.addr; wdata1 = v.din; waddr1 = v.rd; wreg1 = v.wr;
    #1;
    check($sformatf("v%0d_stall_idle", id), stall1, is_mem(v.op));
    st = 0; c = 0;
    do begin
      @(negedge clk);
      c++;
      if (stall1) st++;
    end while (stall1 && c < 100);
    check($sformatf("v%0d_done", id), stall1, 0);
    check($sformatf("v%0d_stall_cycles", id), st, v.exp_stall);
    check($sformatf("v%0d_wreg", id), wreg_o1, v.exp_wreg);
    if (v.exp_wreg) begin
      check($sformatf("v%0d_wdata", id), wdata_o1, v.exp_data);
      check($sformatf("v%0d_waddr", id), waddr_o1, v.rd);
    end
    check($sformatf("v%0d_beats", id), nbeat, v.exp_beats);
    for (int k = 0; k < nbeat && k < 8; k++)
      check($sformatf("v%0d_beat%0d_addr", id, k), beat_addr[k], v.addr + k);
    op1 = EXE_OP_NOP; wreg1 = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_wreg_single", id), wreg_o1, 0);
  endtask

  initial begin
    int st, pulses, rv0;
    vec_t mv;
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st, pulses, rv0;
    vec_t mv;
    rst = 1'b1;
    op1 = EXE_OP_NOP; addr1 = '0; wdata1 = '0; waddr1 = '0; wreg1 = 1'b0;
    op2 = EXE_OP_NOP; addr2 = '0; wdata2 = '0; waddr2 = '0; wreg2 = 1'b0;
    bus2.gnt = 1'b0; bus2.rvalid = 1'b0; bus2.rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
    mem[10'h104] = 8'hAA; mem[10'h105] = 8'hBB;
    mem[10'h200] = 8'h80; mem[10'h204] = 8'hFE; mem[10'h205] = 8'h81;

    vt[0]  = '{EXE_OP_ADD, 32'h0,   32'h5,        5'd3,  1'b1, 0, 0, 1'b1, 32'h0000_0005};
    vt[1]  = '{EXE_OP_LW,  32'h100, 32'h0,        5'd5,  1'b1, 8, 4, 1'b1, 32'h1234_5678};
    vt[2]  = '{EXE_OP_LB,  32'h200, 32'h0,        5'd6,  1'b1, 2, 1, 1'b1, 32'hFFFF_FF80};
    vt[3]  = '{EXE_OP_LBU, 32'h200, 32'h0,        5'd7,  1'b1, 2, 1, 1'b1, 32'h0000_0080};
    vt[4]  = '{EXE_OP_LH,  32'h204, 32'h0,        5'd8,  1'b1, 4, 2, 1'b1, 32'hFFFF_81FE};
    vt[5]  = '{EXE_OP_LHU, 32'h204, 32'h0,        5'd8,  1'b1, 4, 2, 1'b1, 32'h0000_81FE};
    vt[6]  = '{EXE_OP_SW,  32'h300, 32'hCAFEBABE, 5'd0,  1'b0, 4, 4, 1'b0, 32'h0};
    vt[7]  = '{EXE_OP_LW,  32'h300, 32'h0,        5'd9,  1'b1, 8, 4, 1'b1, 32'hCAFE_BABE};
    vt[8]  = '{EXE_OP_SB,  32'h310, 32'h123456A5, 5'd0,  1'b0, 1, 1, 1'b0, 32'h0};
    vt[9]  = '{EXE_OP_LW,  32'h310, 32'h0,        5'd10, 1'b1, 8, 4, 1'b1, 32'h0000_00A5};
    vt[10] = '{EXE_OP_SH,  32'h320, 32'h00007F01, 5'd0,  1'b0, 2, 2, 1'b0, 32'h0};
    vt[11] = '{EXE_OP_LH,  32'h320, 32'h0,        5'd11, 1'b1, 4, 2, 1'b1, 32'h0000_7F01};

    repeat (2) @(negedge clk);
    check("rst_wreg", wreg_o1, 0);
    check("rst_wdata", wdata_o1, 0);
    check("rst_waddr", waddr_o1, 0);
    check("rst_stall", stall1, 0);
    check("rst_req", bus1.req, 0);
    check("rst_be_addr", {bus1.be, bus1.addr[30:0]}, 0);
    check("rst_exc", exc1, 0);
    check("rst_req2", bus2.req, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

`ifdef LSU_MISALIGN_EXC_EN
    nbeat = 0;
    op1 = EXE_OP_LW; addr1 = 32'h102; waddr1 = 5'd12; wreg1 = 1'b1;
    #1 check("mis_stall_idle", stall1, 1);
    @(negedge clk);
    check("mis_exc", exc1, 1);
    check("mis_stall", stall1, 0);
    check("mis_wreg", wreg_o1, 0);
    check("mis_req", bus1.req, 0);
    op1 = EXE_OP_NOP; wreg1 = 1'b0;
    @(negedge clk);
    check("mis_exc_pulse", exc1, 0);
    check("mis_beats", nbeat, 0);
`else
    mv = '{EXE_OP_LW, 32'h102, 32'h0, 5'd12, 1'b1, 8, 4, 1'b1, 32'hBBAA_1234};
    run_vec(mv, 12);
    check("mis_exc_tied", exc1, 0);
`endif

    // Reset while a request waits for its grant: req must drop without a clock edge.
    gnt_delay = 5;
    op1 = EXE_OP_LW; addr1 = 32'h100; waddr1 = 5'd5; wreg1 = 1'b1;
    @(negedge clk);
    check("arst_req_before", bus1.req, 1);
    check("arst_addr_before", bus1.addr, 32'h100);
    @(negedge clk);
    op1 = EXE_OP_NOP; wreg1 = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_req_drop", bus1.req, 0);
    check("arst_stall", stall1, 0);
    @(negedge clk);
    rst = 1'b0;
    gnt_delay = 0;
    @(negedge clk);

    // Reset while waiting for read data; the late rvalid must be ignored.
    rv_extra = 3;
    op1 = EXE_OP_LW; addr1 = 32'h100; waddr1 = 5'd5; wreg1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wrst_in_wait", {stall1, bus1.req}, 2'b10);
    rv0 = rv_cnt;
    op1 = EXE_OP_NOP; wreg1 = 1'b0;
    rst = 1'b1;
    #1;
    check("wrst_req", bus1.req, 0);
    check("wrst_stall", stall1, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (wreg_o1 || bus1.req || stall1) pulses++;
    end
    check("wrst_late_rvalid_seen", rv_cnt - rv0, 1);
    check("wrst_no_activity", pulses, 0);
    rv_extra = 0;
    run_vec(vt[1], 20);

    // Halfword store on the 2-byte bus with the grant held off for 3 cycles.
    op2 = EXE_OP_SH; addr2 = 32'h300; wdata2 = 32'h1234BEEF; waddr2 = '0; wreg2 = 1'b0;
    #1 check("sh_stall_idle", stall2, 1);
    st = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (stall2) st++;
      check($sformatf("sh_c%0d_req_we", c), {bus2.req, bus2.we}, 2'b11);
      check($sformatf("sh_c%0d_be", c), bus2.be, 2'b11);
      check($sformatf("sh_c%0d_wdata", c), bus2.wdata, 32'hBEEF);
      check($sformatf("sh_c%0d_addr", c), bus2.addr, 32'h300);
      bus2.gnt = (c == 4);
    end
    @(negedge clk);
    bus2.gnt = 1'b0;
    op2 = EXE_OP_NOP;
    check("sh_stall_cycles", st, 4);
    check("sh_done_stall", stall2, 0);
    check("sh_wreg", wreg_o2, 0);
    check("sh_req_after", bus2.req, 0);
    @(negedge clk);
    check("sh_idle_wreg", wreg_o2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
